spmv_sram_arbiter: RTL and testbench

SPMV_SRAM_ARBITER -- requirements
Module: spmv_sram_arbiter

---
 rtl/spmv_sram_arbiter.sv | 128 ++++++++++++
 tb/tb_spmv_sram_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/spmv_sram_arbiter.sv
// Single-port SRAM arbiter for the SpMV datapath: two burst readers (vector, pointer)
// and one burst writer (result) share one SRAM word port through an IDLE/BURST/DRAIN/DONE FSM.
module spmv_sram_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 256
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [2:0]        i_req,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [ADDR_W-1:0] i_addr2,
  input  logic [2:0]        i_len0,
  input  logic [2:0]        i_len1,
  input  logic [2:0]        i_len2,
  input  logic [DATA_W-1:0] i_wdata2,
  input  logic [DATA_W-1:0] i_sram_rdata,
  output logic [2:0]        o_gnt,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic              o_sram_wr_en,
  output logic [DATA_W-1:0] o_sram_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic [1:0]        o_rvalid,
  output logic [2:0]        o_done,
  output logic [1:0]        o_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BURST = 2'b01,
    DRAIN = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t            state, state_next;
  logic [1:0]        win, pick;
  logic [ADDR_W-1:0] base, pick_addr;
  logic [2:0]        len, beat, pick_len;
  logic              rr_pref;   // 1: reader 1 preferred on a reader tie
  logic              last_wr;   // previous burst belonged to the writer
  logic [1:0]        rvalid;
  logic [2:0]        win_onehot;
  logic              win_is_wr;

  assign win_is_wr  = (win == 2'd2);
  assign win_onehot = 3'b001 << win;

  // Writer normally wins, but yields once to a waiting reader after its own burst
  // so a continuously requesting writer interleaves with the readers.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    pick = 2'd0;
    if (i_req[2] && !(last_wr && |i_req[1:0])) pick = 2'd2;
    else if (i_req[1] && (!i_req[0] || rr_pref)) pick = 2'd1;
  end

  always_comb begin
    pick_addr = i_addr0;
    pick_len  = i_len0;
    case (pick)
      2'd1:    begin pick_addr = i_addr1; pick_len = i_len1; end
      2'd2:    begin pick_addr = i_addr2; pick_len = i_len2; end
      default: ;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (|i_req) state_next = BURST;
      BURST:   if (beat == len) state_next = win_is_wr ? DONE : DRAIN;
      DRAIN:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_gnt        = '0;
    o_sram_addr  = '0;
    o_sram_wr_en = 1'b0;
    o_sram_wdata = '0;
    o_done       = '0;
    if (state == BURST) begin
      o_gnt        = win_onehot;
      o_sram_addr  = base + ADDR_W'(beat);
      o_sram_wr_en = win_is_wr;
      if (win_is_wr) o_sram_wdata = i_wdata2;
    end
    if (state == DONE) o_done = win_onehot;
  end

  assign o_rvalid = rvalid;
  assign o_rdata  = (|rvalid) ? i_sram_rdata : '0;
  assign o_state  = state;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      win     <= '0;
      base    <= '0;
      len     <= '0;
      beat    <= '0;
      rr_pref <= 1'b0;
      last_wr <= 1'b0;
      rvalid  <= '0;
    end else begin
      state  <= state_next;
      rvalid <= (state == BURST && !win_is_wr) ? win_onehot[1:0] : 2'b00;
      case (state)
        IDLE: if (|i_req) begin
          win  <= pick;
          base <= pick_addr;
          len  <= pick_len;
          beat <= '0;
        end
        BURST: beat <= beat + 3'd1;
        DONE: begin
          last_wr <= win_is_wr;
          if (!win_is_wr) rr_pref <= (win == 2'd0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spmv_sram_arbiter.sv
// Bench for spmv_sram_arbiter: directed scenarios then random traffic, all checked
// cycle by cycle against a transaction-level schedule built from the burst timing rules.
module tb_spmv_sram_arbiter;

  localparam int NC = 2048;

  logic         clk, rst;
  logic [2:0]   req;
  logic [4:0]   addr0, addr1, addr2;
  logic [2:0]   len0, len1, len2;
  logic [255:0] wdata2, sram_rdata;
  logic [2:0]   gnt, done;
  logic [4:0]   sram_addr;
  logic         sram_wr_en;
  logic [255:0] sram_wdata, rdata;
  logic [1:0]   rvalid, state;

  spmv_sram_arbiter dut (
    .i_clk(clk), .i_rst(rst), .i_req(req),
    .i_addr0(addr0), .i_addr1(addr1), .i_addr2(addr2),
    .i_len0(len0), .i_len1(len1), .i_len2(len2),
    .i_wdata2(wdata2), .i_sram_rdata(sram_rdata),
    .o_gnt(gnt), .o_sram_addr(sram_addr), .o_sram_wr_en(sram_wr_en),
    .o_sram_wdata(sram_wdata), .o_rdata(rdata), .o_rvalid(rvalid),
    .o_done(done), .o_state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected per-cycle outputs; an untouched entry means an idle cycle.
  logic [1:0] e_state [NC];
  logic [2:0] e_gnt   [NC];
  logic [2:0] e_done  [NC];
  logic [4:0] e_addr  [NC];
  logic       e_wr    [NC];
  logic [1:0] e_rv    [NC];

  int cyc, next_idle, n_checks, n_fail;
  int m_last_reader;   // reader granted most recently
  bit m_last_wr;       // last burst was the writer's

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom())};
    return r;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic clear_from(input int n);
    for (int c = n; c < n + 24 && c < NC; c++) begin
      e_state[c] = 2'd0; e_gnt[c] = 3'd0; e_done[c] = 3'd0;
      e_addr[c] = 5'd0; e_wr[c] = 1'b0; e_rv[c] = 2'd0;
    end
  endtask

  // Burst seen in IDLE at cycle n: beats on n+1..n+1+len, readers get data one
  // cycle later and finish with DRAIN then DONE; the writer goes straight to DONE.
  task automatic schedule(input int n);
    int w, l, c;
    logic [4:0] a;
    bit readers_waiting;
    readers_waiting = (req[1:0] != 2'b00);
    if (req[2] && !(m_last_wr && readers_waiting)) w = 2;
    else if (req[0] && req[1]) w = (m_last_reader == 0) ? 1 : 0;
    else w = req[1] ? 1 : 0;
    case (w)
      0: begin a = addr0; l = int'(len0); end
      1: begin a = addr1; l = int'(len1); end
      default: begin a = addr2; l = int'(len2); end
    endcase
    m_last_wr = (w == 2);
    if (w != 2) m_last_reader = w;
    for (int b = 0; b <= l; b++) begin
      c = n + 1 + b;
      e_state[c] = 2'd1;
      e_gnt[c]   = 3'(1 << w);
      e_addr[c]  = 5'((int'(a) + b) % 32);
      e_wr[c]    = (w == 2);
      if (w != 2) e_rv[c + 1] = 2'(1 << w);
    end
    if (w == 2) begin
      e_state[n + l + 2] = 2'd3;
      e_done[n + l + 2]  = 3'b100;
      next_idle = n + l + 3;
    end else begin
      e_state[n + l + 2] = 2'd2;
      e_state[n + l + 3] = 2'd3;
      e_done[n + l + 3]  = 3'(1 << w);
      next_idle = n + l + 4;
    end
  endtask

  task automatic cycle();
    sram_rdata = rnd256();
    if (rst) begin
      clear_from(cyc);
      m_last_reader = 1;
      m_last_wr = 1'b0;
      next_idle = cyc + 1;
    end else if (cyc == next_idle) begin
      if (req != 3'b000) schedule(cyc);
      else next_idle = cyc + 1;
    end
    @(negedge clk);
    check("state",  256'(state),      256'(e_state[cyc]));
    check("gnt",    256'(gnt),        256'(e_gnt[cyc]));
    check("addr",   256'(sram_addr),  256'(e_addr[cyc]));
    check("wr_en",  256'(sram_wr_en), 256'(e_wr[cyc]));
    check("wdata",  sram_wdata,       e_wr[cyc] ? wdata2 : 256'd0);
    check("rvalid", 256'(rvalid),     256'(e_rv[cyc]));
    check("rdata",  rdata,            (e_rv[cyc] != 2'd0) ? sram_rdata : 256'd0);
    check("done",   256'(done),       256'(e_done[cyc]));
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    cyc = 0; next_idle = 0; n_checks = 0; n_fail = 0;
    m_last_reader = 1; m_last_wr = 1'b0;
    clear_from(0);
    for (int c = 0; c < NC; c++) begin
      e_state[c] = 2'd0; e_gnt[c] = 3'd0; e_done[c] = 3'd0;
      e_addr[c] = 5'd0; e_wr[c] = 1'b0; e_rv[c] = 2'd0;
    end
    rst = 1'b1; req = 3'b000;
    addr0 = 5'd0; addr1 = 5'd0; addr2 = 5'd0;
    len0 = 3'd0; len1 = 3'd0; len2 = 3'd0;
    wdata2 = '0; sram_rdata = '0;
    run(2);
    rst = 1'b0;
    run(1);

    // Reader 0 burst, request dropped after one cycle.
    req = 3'b001; addr0 = 5'd4; len0 = 3'd3;
    run(1);
    req = 3'b000;
    run(7);

    // Single-beat writer burst.
    req = 3'b100; addr2 = 5'd16; len2 = 3'd0; wdata2 = {32{8'hA5}};
    run(1);
    req = 3'b000;
    run(4);

    // All three requesting continuously.
    req = 3'b111; addr0 = 5'd1; addr1 = 5'd9; addr2 = 5'd20;
    len0 = 3'd1; len1 = 3'd2; len2 = 3'd1; wdata2 = rnd256();
    run(40);

    // Both readers after reset, then the wrapping pointer burst.
    req = 3'b000; rst = 1'b1;
    run(1);
    rst = 1'b0; req = 3'b011;
    run(30);
    req = 3'b000;
    run(6);
    req = 3'b010; addr1 = 5'd30; len1 = 3'd3;
    run(1);
    req = 3'b000;
    run(8);

    // Reset in the second beat of an 8-beat read, then a normal pointer burst.
    req = 3'b001; addr0 = 5'd0; len0 = 3'd7;
    run(2);
    req = 3'b000;
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    req = 3'b010; addr1 = 5'd12; len1 = 3'd2;
    run(1);
    req = 3'b000;
    run(8);

    // Random traffic; inputs change every cycle, including mid-burst.
    for (int i = 0; i < 1500; i++) begin
      req    = ($urandom_range(0, 9) < 3) ? 3'b000 : 3'($urandom_range(1, 7));
      addr0  = 5'($urandom()); addr1 = 5'($urandom()); addr2 = 5'($urandom());
      len0   = 3'($urandom()); len1  = 3'($urandom()); len2  = 3'($urandom());
      wdata2 = rnd256();
      rst    = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 1'b0; req = 3'b000;
    run(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
